// File: rtl/cpu_axi_bridge_pkg.sv
// Shared types and constants for the CPU-to-AXI3 bridge.
package cpu_axi_bridge_pkg;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} AxiRdState;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} AxiWrState;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_ID_INST    = 4'd0;
  localparam logic [3:0] AXI_ID_DATA    = 4'd1;
  localparam logic [1:0] AXI_SIZE_WORD  = 2'd2;

endpackage

// File: rtl/cpu_axi_bridge.sv
// Turns the fetch and load/store request channels into single-beat AXI3
// transactions, with one read and one write outstanding at a time.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
#(
  parameter logic [3:0] ID_INST = AXI_ID_INST,
  parameter logic [3:0] ID_DATA = AXI_ID_DATA,
  parameter int         ADDR_W  = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [ADDR_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [ADDR_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [ADDR_W-1:0] data_rdata,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [ADDR_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  output logic [3:0]        wid,
  output logic [ADDR_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [3:0]        bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  AxiRdState         rd_state, rd_next;
  AxiWrState         wr_state, wr_next;
  logic [ADDR_W-1:0] rd_addr, wr_addr, wr_data;
  logic [1:0]        rd_size, wr_size;
  logic [3:0]        rd_id, wr_strb;
  logic              aw_done, w_done;
  logic              data_rd_req, data_wr_req, data_rd_ok, data_wr_ok, rd_accept;
  logic              data_rd_inflight, aw_hs, w_hs, r_hs;
  logic              unused_ok;

  assign unused_ok = ^{rid, rresp, rlast, bid, bresp};

  // A store must wait for any in-flight data read so data-side order holds.
  assign data_rd_req      = data_req & ~data_wr;
  assign data_wr_req      = data_req & data_wr;
  assign data_rd_inflight = (rd_state != R_IDLE) && (rd_id == ID_DATA);
  assign data_rd_ok       = data_rd_req && (rd_state == R_IDLE) && (wr_state == W_IDLE);
  assign data_wr_ok       = data_wr_req && (wr_state == W_IDLE) && !data_rd_inflight;
  assign inst_addr_ok     = inst_req && (rd_state == R_IDLE) && !(data_rd_req && (wr_state == W_IDLE));
  assign data_addr_ok     = data_rd_ok | data_wr_ok;
  assign rd_accept        = data_rd_ok | inst_addr_ok;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign r_hs  = rvalid & rready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state <= R_IDLE;
      rd_addr  <= '0;
      rd_size  <= '0;
      rd_id    <= '0;
    end else begin
      rd_state <= rd_next;
      if (rd_accept) begin
        rd_addr <= data_rd_ok ? data_addr : inst_addr;
        rd_size <= data_rd_ok ? data_size : AXI_SIZE_WORD;
        rd_id   <= data_rd_ok ? ID_DATA : ID_INST;
      end
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (rd_accept) rd_next = R_ADDR;
      R_ADDR:  if (arready)   rd_next = R_DATA;
      R_DATA:  if (rvalid)    rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    arvalid      = (rd_state == R_ADDR);
    rready       = (rd_state == R_DATA);
    inst_data_ok = r_hs && (rd_id == ID_INST);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state <= W_IDLE;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_size  <= '0;
      wr_strb  <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_next;
      if (data_wr_ok) begin
        wr_addr <= data_addr;
        wr_data <= data_wdata;
        wr_size <= data_size;
        wr_strb <= data_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (wr_state == W_REQ) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (data_wr_ok) wr_next = W_REQ;
      W_REQ:   if ((aw_done | aw_hs) & (w_done | w_hs)) wr_next = W_RESP;
      W_RESP:  if (bvalid) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    awvalid = (wr_state == W_REQ) && !aw_done;
    wvalid  = (wr_state == W_REQ) && !w_done;
    bready  = (wr_state == W_RESP);
  end

  // Data read returns and store responses never overlap on the data port.
  assign data_data_ok = (r_hs && (rd_id != ID_INST)) | (bvalid & bready);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arid    = rd_id;
  assign araddr  = rd_addr;
  assign arsize  = {1'b0, rd_size};
  assign arlen   = '0;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;

  assign awid    = ID_DATA;
  assign awaddr  = wr_addr;
  assign awsize  = {1'b0, wr_size};
  assign awlen   = '0;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign wid     = ID_DATA;
  assign wdata   = wr_data;
  assign wstrb   = wr_strb;
  assign wlast   = 1'b1;

endmodule
